// File: rtl/incline_conditioner_if.sv
// Bus bundle between the incline source, the conditioner and the desired-drive math.
// The master drives samples and controls; the slave returns the conditioned output and diagnostics.
interface incline_conditioner_if #(
    parameter int IN_W   = 13,
    parameter int OUT_W  = 10,
    parameter int SLEW_W = 6,
    parameter int CNT_W  = 8
);
    logic signed [IN_W-1:0]  incline;
    logic                    vld;
    logic        [SLEW_W-1:0] slew_max;
    logic                    clr;
    logic signed [OUT_W-1:0] incline_sat;
    logic                    out_vld;
    logic                    ovfl_sticky;
    logic        [CNT_W-1:0] sat_cnt;

    modport master (
        output incline, vld, slew_max, clr,
        input  incline_sat, out_vld, ovfl_sticky, sat_cnt
    );

    modport slave (
        input  incline, vld, slew_max, clr,
        output incline_sat, out_vld, ovfl_sticky, sat_cnt
    );
endinterface

// File: rtl/incline_conditioner.sv
// Two-stage incline conditioner: saturate to a signed OUT_W range, then optionally
// slew-rate limit between samples; keeps sticky overflow and a saturating clip counter.
module incline_conditioner #(
    parameter int IN_W   = 13,
    parameter int OUT_W  = 10,
    parameter int SLEW_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    incline_conditioner_if.slave bus
);
    localparam int DW = ((OUT_W > SLEW_W) ? OUT_W : SLEW_W) + 2;
    localparam logic signed [OUT_W-1:0] SAT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic        [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

    logic                    sign_s;
    logic [IN_W-OUT_W-1:0]   guard_s;
    logic                    pos_ovf_s;
    logic                    neg_ovf_s;
    logic                    is_sat_s;
    logic                    acc_sat_s;
    logic signed [OUT_W-1:0] sat_val_s;

    logic signed [OUT_W-1:0] s1_val_r;
    logic                    s1_vld_r;
    logic signed [OUT_W-1:0] sat_r;
    logic                    out_vld_r;
    logic                    sticky_r;
    logic        [CNT_W-1:0] cnt_r;
    logic                    primed_r;

    logic signed [DW-1:0]    diff_s;
    logic signed [DW-1:0]    step_s;
    logic        [OUT_W-1:0] slew_out_s;
    logic                    bypass_s;
    logic signed [OUT_W-1:0] next_s;

    // Overflow shows as guard bits that disagree with the sign bit.
    always_comb begin
        sign_s    = bus.incline[IN_W-1];
        guard_s   = bus.incline[IN_W-2:OUT_W-1];
        pos_ovf_s = ~sign_s & (|guard_s);
        neg_ovf_s = sign_s & ~(&guard_s);
        is_sat_s  = pos_ovf_s | neg_ovf_s;
        acc_sat_s = bus.vld & is_sat_s;
        if (pos_ovf_s) begin
            sat_val_s = SAT_MAX;
        end else if (neg_ovf_s) begin
            sat_val_s = SAT_MIN;
        end else begin
            sat_val_s = bus.incline[OUT_W-1:0];
        end
    end

    // Slew step: a clear in the update cycle counts as unprimed, so an in-flight sample passes.
    always_comb begin
        diff_s     = {{(DW-OUT_W){s1_val_r[OUT_W-1]}}, s1_val_r}
                   - {{(DW-OUT_W){sat_r[OUT_W-1]}}, sat_r};
        step_s     = {{(DW-SLEW_W){1'b0}}, bus.slew_max};
        slew_out_s = OUT_W'(bus.slew_max);
        bypass_s   = (bus.slew_max == {SLEW_W{1'b0}}) | ~primed_r | bus.clr;
        if (bypass_s) begin
            next_s = s1_val_r;
        end else if (diff_s > step_s) begin
            next_s = sat_r + slew_out_s;
        end else if (diff_s < -step_s) begin
            next_s = sat_r - slew_out_s;
        end else begin
            next_s = s1_val_r;
        end
    end

    // Stage 1: saturated sample register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_val_r <= '0;
            s1_vld_r <= 1'b0;
        end else begin
            s1_vld_r <= bus.vld;
            if (bus.vld) begin
                s1_val_r <= sat_val_s;
            end
        end
    end

    // Stage 2: conditioned output and its valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_r     <= '0;
            out_vld_r <= 1'b0;
        end else begin
            out_vld_r <= s1_vld_r;
            if (s1_vld_r) begin
                sat_r <= next_s;
            end
        end
    end

    // Slew history: any output update primes; a clear without an update unprimes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed_r <= 1'b0;
        end else if (s1_vld_r) begin
            primed_r <= 1'b1;
        end else if (bus.clr) begin
            primed_r <= 1'b0;
        end
    end

    // Diagnostics: clear first, then account for the sample accepted this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= 1'b0;
            cnt_r    <= '0;
        end else if (bus.clr) begin
            sticky_r <= acc_sat_s;
            cnt_r    <= acc_sat_s ? CNT_W'(1'b1) : {CNT_W{1'b0}};
        end else if (acc_sat_s) begin
            sticky_r <= 1'b1;
            if (cnt_r != CNT_FULL) begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end
        end
    end

    assign bus.incline_sat = sat_r;
    assign bus.out_vld     = out_vld_r;
    assign bus.ovfl_sticky = sticky_r;
    assign bus.sat_cnt     = cnt_r;
endmodule
